usb_rx_pid_decoder: RTL and testbench
=====================================

Name: usb_rx_pid_decoder

Overview:
- Parametrised successor to the receive-path bitstream decoder.
- Sits between the bit unstuffer and rc_crc / protocolFSM.
- Takes destuffed serial bits framed by start_decode/end_decode, captures and validates the PID (low half must equal the bitwise complement of the high half), and classifies the packet type.
- Forwards bits to rc_crc with start/end strobes, checks payload length per packet type, and holds a PID or length error until protocolFSM acknowledges it.

Parameters:
PID_BITS, 8, PID field width in bits; must be even; sent LSB first.
MAX_BITS, 1024, maximum legal payload bits after the PID (DATA packets).
CRC_PID, 1, 1: PID bits are forwarded to rc_crc; 0: only payload bits are forwarded.
CNT_W, $clog2(MAX_BITS+2), payload bit counter width (derived; do not override).

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous and active-low
abort  in  1  synchronous abort; returns block to IDLE
start_decode  in  1  1-cycle strobe; s_in carries the first packet bit on this cycle
end_decode  in  1  1-cycle strobe; end of packet; s_in not part of packet on this cycle
s_in  in  1  destuffed serial bit
bit_valid  in  1  s_in holds a packet bit this cycle (ignored on the start_decode cycle: bit always valid)
s_out  out  1  bit to rc_crc
s_out_valid  out  1  s_out carries a bit for rc_crc
start_rc_crc  out  1  1-cycle strobe accompanying the first forwarded bit
end_rc_crc  out  1  1-cycle strobe closing an rc_crc frame
pid  out  PID_BITS/2  captured PID value (low half)
pid_type  out  2  pid[1:0]: 00 NONE/special, 01 TOKEN, 10 HSHAKE, 11 DATA
pid_valid  out  1  pid/pid_type valid for the current packet
bit_count  out  CNT_W  payload bits received; saturates at MAX_BITS+1
pkt_ok  out  1  1-cycle pulse: packet ended with no error
PID_error  out  1  held: bad or truncated PID
len_error  out  1  held: payload length illegal for pid_type
bs_decoder_wait  out  1  high only in IDLE
rc_PIDerror  in  1  protocolFSM error acknowledge

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - State IDLE.
  - pid, pid_valid, bit_count, PID_error, len_error, pkt_ok all 0.
  - Combinational outputs follow from IDLE: bs_decoder_wait=1, all others 0.
- Priority: rst_n > abort > normal operation.
- abort:
  - Next state IDLE; clears bit_count, pid_valid and the error flags.
  - Masks s_out_valid, start_rc_crc, end_rc_crc and pkt_ok in the abort cycle.
- States: IDLE, PID, PAYLOAD, DRAIN, DONE, ERROR.
- IDLE:
  - On start_decode, shift s_in into PID reg, set PID bit index to 1, go to PID.
  - If CRC_PID=1: start_rc_crc=1, s_out=s_in, s_out_valid=1 (combinational, same cycle).
  - end_decode is ignored in IDLE, including when coincident with start_decode.
- PID:
  - Each bit_valid shifts s_in in LSB first.
  - If CRC_PID=1, the bit is forwarded combinationally.
  - When the PID_BITS-th bit arrives, compare the shifted value combinationally.
  - Valid PID:
    - Register pid and pid_valid=1 at that edge; go to PAYLOAD.
  - Invalid PID: go to DRAIN.
  - end_decode before PID complete:
    - PID_error=1, go to ERROR.
    - end_rc_crc=1 if CRC_PID=1.
- PAYLOAD:
  - Each bit_valid forwards s_in (s_out_valid=1) and increments bit_count, saturating at MAX_BITS+1.
  - If CRC_PID=0, the first payload bit also raises start_rc_crc.
  - On end_decode: end_rc_crc=1 iff start_rc_crc pulsed for this packet.
  - Length check at end_decode:
    - HSHAKE: bit_count must be 0.
    - TOKEN: bit_count must be 16.
    - DATA: 16 ≤ bit_count ≤ MAX_BITS and bit_count%8=0.
    - NONE: no check.
  - Length pass: go to DONE. Length fail: len_error=1, go to ERROR.
- DRAIN:
  - Nothing forwarded; bit_count frozen.
  - On end_decode: PID_error=1, go to ERROR; end_rc_crc=1 iff CRC_PID=1.
- DONE: pkt_ok=1 for one cycle, then IDLE. pid/pid_valid hold until the next start_decode.
- ERROR:
  - Flags held.
  - When rc_PIDerror=1, go to IDLE; flags clear at that edge, so they fall the cycle after the ack.
- Invariant: start_decode outside IDLE is ignored.
- Invariant: end_rc_crc pulses exactly once iff start_rc_crc pulsed for the packet.
- Invariant: bit_valid=0 cycles never forward or count.

Test Plan:
- ACK (PID 0xD2, bits 0,1,0,0,1,0,1,1), then end_decode, CRC_PID=1 -> start_rc_crc on cycle 0; 8 forwarded bits; pid=2, pid_type=10; end_rc_crc on end cycle; pkt_ok one cycle later; bit_count=0.
- DATA0 (0xC3) with 64 payload bits and random bit_valid gaps, CRC_PID=0 -> start_rc_crc with first payload bit; exactly 64 s_out_valid; bit_count=64; pkt_ok=1.
- IN token (0x69) with 15 payload bits -> len_error=1 held; rc_PIDerror pulse -> len_error low the next cycle; bs_decoder_wait=1.
- Bad PID 0xD3 then 20 bits and end_decode -> no forwarding after the PID; PID_error=1 only after end_decode; end_rc_crc iff CRC_PID=1.
- end_decode after 5 PID bits -> PID_error=1, state ERROR; abort asserted together with rc_PIDerror -> IDLE, all flags 0.
- abort mid-PAYLOAD of DATA1 (0x4B) -> no end_rc_crc; next cycle bs_decoder_wait=1, bit_count=0; a following valid packet decodes normally.

Source files
------------

// File: rtl/usb_rx_pid_decoder.sv
// Receive-path decoder: captures and validates the PID, forwards bits to rc_crc,
// checks payload length by packet type and holds errors until acknowledged.
module usb_rx_pid_decoder #(
  parameter int PID_BITS = 8,
  parameter int MAX_BITS = 1024,
  parameter int CRC_PID  = 1,
  parameter int CNT_W    = $clog2(MAX_BITS + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  abort,
  input  logic                  start_decode,
  input  logic                  end_decode,
  input  logic                  s_in,
  input  logic                  bit_valid,
  output logic                  s_out,
  output logic                  s_out_valid,
  output logic                  start_rc_crc,
  output logic                  end_rc_crc,
  output logic [PID_BITS/2-1:0] pid,
  output logic [1:0]            pid_type,
  output logic                  pid_valid,
  output logic [CNT_W-1:0]      bit_count,
  output logic                  pkt_ok,
  output logic                  PID_error,
  output logic                  len_error,
  output logic                  bs_decoder_wait,
  input  logic                  rc_PIDerror
);

  localparam int   HALF   = PID_BITS / 2;
  localparam int   IDX_W  = $clog2(PID_BITS);
  localparam logic CRC_ON = (CRC_PID != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_PAYLOAD, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  state_t                state, state_nx;
  logic [PID_BITS-2:0]   pid_sr;
  logic [PID_BITS-1:0]   pid_sh;
  logic [IDX_W-1:0]      pid_idx;
  logic                  pid_last;
  logic                  pid_good;
  logic                  started;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(MAX_BITS + 1)) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic len_ok(input logic [1:0] t, input logic [CNT_W-1:0] c);
    case (t)
      2'b10:   len_ok = (c == '0);
      2'b01:   len_ok = (c == CNT_W'(16));
      2'b11:   len_ok = (c >= CNT_W'(16)) && (c <= CNT_W'(MAX_BITS)) && (c[2:0] == 3'b000);
      default: len_ok = 1'b1;
    endcase
  endfunction

  // pid_sr keeps the bits received so far; pid_sh is the value including this cycle's bit
  assign pid_sh   = {s_in, pid_sr};
  assign pid_good = (pid_sh[HALF-1:0] == ~pid_sh[PID_BITS-1:HALF]);
  assign pid_last = (pid_idx == IDX_W'(PID_BITS - 1));
  assign pid_type = pid[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start_decode) state_nx = S_PID;
      S_PID: begin
        if (end_decode)                state_nx = S_ERROR;
        else if (bit_valid && pid_last) state_nx = pid_good ? S_PAYLOAD : S_DRAIN;
      end
      S_PAYLOAD: if (end_decode) state_nx = len_ok(pid_type, bit_count) ? S_DONE : S_ERROR;
      S_DRAIN:   if (end_decode) state_nx = S_ERROR;
      S_DONE:    state_nx = S_IDLE;
      S_ERROR:   if (rc_PIDerror) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_comb begin
    s_out_valid     = 1'b0;
    start_rc_crc    = 1'b0;
    end_rc_crc      = 1'b0;
    pkt_ok          = 1'b0;
    bs_decoder_wait = 1'b0;
    case (state)
      S_IDLE: begin
        bs_decoder_wait = 1'b1;
        if (start_decode && CRC_ON) begin
          s_out_valid  = 1'b1;
          start_rc_crc = 1'b1;
        end
      end
      S_PID: begin
        if (end_decode)                  end_rc_crc  = started;
        else if (bit_valid && CRC_ON)    s_out_valid = 1'b1;
      end
      S_PAYLOAD: begin
        if (end_decode) end_rc_crc = started;
        else if (bit_valid) begin
          s_out_valid  = 1'b1;
          start_rc_crc = !started;
        end
      end
      S_DRAIN: if (end_decode) end_rc_crc = started;
      S_DONE:  pkt_ok = 1'b1;
      default: ;
    endcase
    if (abort) begin
      s_out_valid  = 1'b0;
      start_rc_crc = 1'b0;
      end_rc_crc   = 1'b0;
      pkt_ok       = 1'b0;
    end
  end

  assign s_out = s_out_valid & s_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pid_sr    <= '0;
      pid_idx   <= '0;
      pid       <= '0;
      pid_valid <= 1'b0;
      bit_count <= '0;
      PID_error <= 1'b0;
      len_error <= 1'b0;
      started   <= 1'b0;
    end else if (abort) begin
      pid_valid <= 1'b0;
      bit_count <= '0;
      PID_error <= 1'b0;
      len_error <= 1'b0;
      started   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start_decode) begin
          pid_sr    <= pid_sh[PID_BITS-1:1];
          pid_idx   <= IDX_W'(1);
          pid_valid <= 1'b0;
          bit_count <= '0;
          started   <= CRC_ON;
        end
        S_PID: begin
          if (end_decode) PID_error <= 1'b1;
          else if (bit_valid) begin
            pid_sr  <= pid_sh[PID_BITS-1:1];
            pid_idx <= pid_idx + IDX_W'(1);
            if (pid_last && pid_good) begin
              pid       <= pid_sh[HALF-1:0];
              pid_valid <= 1'b1;
            end
          end
        end
        S_PAYLOAD: begin
          if (end_decode) begin
            if (!len_ok(pid_type, bit_count)) len_error <= 1'b1;
          end else if (bit_valid) begin
            bit_count <= sat_inc(bit_count);
            if (start_rc_crc) started <= 1'b1;
          end
        end
        S_DRAIN: if (end_decode) PID_error <= 1'b1;
        S_ERROR: if (rc_PIDerror) begin
          PID_error <= 1'b0;
          len_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_pid_decoder.sv
// Bench for usb_rx_pid_decoder: two instances (CRC_PID=1/MAX_BITS=1024 and
// CRC_PID=0/MAX_BITS=64) share stimulus and are checked against a packet-level model.
module tb_usb_rx_pid_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort, start_decode, end_decode, s_in, bit_valid, rc_PIDerror;
  logic so [2], sov [2], st [2], en [2], okw [2], pv [2], perr [2], lerr [2], wt [2];
  logic [3:0]  pidw [2];
  logic [1:0]  ptw [2];
  logic [10:0] bc1;
  logic [6:0]  bc0;

  usb_rx_pid_decoder #(.PID_BITS(8), .MAX_BITS(1024), .CRC_PID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .start_decode(start_decode),
    .end_decode(end_decode), .s_in(s_in), .bit_valid(bit_valid),
    .s_out(so[1]), .s_out_valid(sov[1]), .start_rc_crc(st[1]), .end_rc_crc(en[1]),
    .pid(pidw[1]), .pid_type(ptw[1]), .pid_valid(pv[1]), .bit_count(bc1),
    .pkt_ok(okw[1]), .PID_error(perr[1]), .len_error(lerr[1]),
    .bs_decoder_wait(wt[1]), .rc_PIDerror(rc_PIDerror));

  usb_rx_pid_decoder #(.PID_BITS(8), .MAX_BITS(64), .CRC_PID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .abort(abort), .start_decode(start_decode),
    .end_decode(end_decode), .s_in(s_in), .bit_valid(bit_valid),
    .s_out(so[0]), .s_out_valid(sov[0]), .start_rc_crc(st[0]), .end_rc_crc(en[0]),
    .pid(pidw[0]), .pid_type(ptw[0]), .pid_valid(pv[0]), .bit_count(bc0),
    .pkt_ok(okw[0]), .PID_error(perr[0]), .len_error(lerr[0]),
    .bs_decoder_wait(wt[0]), .rc_PIDerror(rc_PIDerror));

  int checks = 0;
  int failures = 0;

  bit mon_en = 1'b0;
  int cyc = 0;
  int start_cnt [2], start_bad [2], end_cnt [2], ok_cnt [2], end_cyc [2], ok_cyc [2], fwd_n [2];
  bit fwd_a [2][2048];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (st[i]) begin
          start_cnt[i]++;
          if (!sov[i] || fwd_n[i] != 0) start_bad[i]++;
        end
        if (sov[i]) begin
          fwd_a[i][fwd_n[i]] = so[i];
          fwd_n[i]++;
        end
        if (en[i])  begin end_cnt[i]++; end_cyc[i] = cyc; end
        if (okw[i]) begin ok_cnt[i]++;  ok_cyc[i]  = cyc; end
      end
    end
  end

  // Packet-level reference model
  bit         pkt_bits [$];
  bit         exp_a [2048];
  int         exp_n, e_bc;
  bit         e_perr, e_lerr, e_ok, e_pv, e_start, e_end;
  logic [3:0] e_pid;

  task automatic model(input bit crc, input int maxb, input int nb, input bit ended);
    logic [7:0] pb;
    bit good, lok;
    int n;
    exp_n = 0; e_perr = 0; e_lerr = 0; e_ok = 0; e_pv = 0; e_pid = '0; e_bc = 0;
    good = 0; pb = '0; lok = 0;
    for (int k = 0; k < nb && k < 8; k++) begin
      pb[k] = pkt_bits[k];
      if (crc) begin exp_a[exp_n] = pkt_bits[k]; exp_n++; end
    end
    if (nb >= 8) begin
      good = (pb[3:0] == ~pb[7:4]);
      if (good) begin
        e_pv = 1; e_pid = pb[3:0];
        for (int k = 8; k < nb; k++) begin exp_a[exp_n] = pkt_bits[k]; exp_n++; end
        n = nb - 8;
        e_bc = (n > maxb + 1) ? maxb + 1 : n;
      end
    end
    if (ended) begin
      if (!good) e_perr = 1;
      else begin
        case (pb[1:0])
          2'b10:   lok = (e_bc == 0);
          2'b01:   lok = (e_bc == 16);
          2'b11:   lok = (e_bc >= 16) && (e_bc <= maxb) && (e_bc % 8 == 0);
          default: lok = 1;
        endcase
        if (lok) e_ok = 1; else e_lerr = 1;
      end
    end else begin
      e_pv = 0; e_bc = 0;
    end
    e_start = (exp_n > 0);
    e_end   = ended && e_start;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_pkt(input logic [7:0] pidv, input int npay, input int trunc,
                         input int abort_at, input int gap_pct, input bit abort_ack,
                         input string name);
    int nb, sent, delivered, mism, gbc;
    bit aborted, any_err;
    bit e_err [2];
    nb = (trunc >= 0) ? trunc : 8 + npay;
    pkt_bits.delete();
    for (int k = 0; k < nb; k++) pkt_bits.push_back(k < 8 ? pidv[k] : bit'($urandom_range(0, 1)));
    for (int i = 0; i < 2; i++) begin
      start_cnt[i] = 0; start_bad[i] = 0; end_cnt[i] = 0; ok_cnt[i] = 0;
      end_cyc[i] = -10; ok_cyc[i] = -10; fwd_n[i] = 0;
    end
    mon_en = 1'b1;
    start_decode = 1'b1; s_in = pkt_bits[0]; bit_valid = 1'(($urandom_range(0, 1)));
    step();
    start_decode = 1'b0;
    sent = 1; aborted = 0;
    while (sent < nb) begin
      if (abort_at >= 0 && sent == abort_at) begin
        abort = 1'b1; bit_valid = 1'b1; s_in = 1'($urandom_range(0, 1));
        step();
        abort = 1'b0; bit_valid = 1'b0; aborted = 1;
        break;
      end
      if ($urandom_range(0, 99) < gap_pct) begin
        bit_valid = 1'b0; s_in = 1'($urandom_range(0, 1));
        start_decode = ($urandom_range(0, 3) == 0);
      end else begin
        bit_valid = 1'b1; s_in = pkt_bits[sent]; sent++; start_decode = 1'b0;
      end
      step();
    end
    start_decode = 1'b0;
    if (!aborted) begin
      end_decode = 1'b1; bit_valid = 1'($urandom_range(0, 1)); s_in = 1'($urandom_range(0, 1));
      step();
      end_decode = 1'b0;
    end
    bit_valid = 1'b0; s_in = 1'b0;
    repeat (3) step();
    mon_en = 1'b0;
    delivered = aborted ? abort_at : nb;
    any_err = 0;

    for (int i = 0; i < 2; i++) begin
      model(i == 1, (i == 1) ? 1024 : 64, delivered, !aborted);
      e_err[i] = e_perr || e_lerr;
      any_err |= e_err[i];
      gbc = (i == 1) ? int'(bc1) : int'(bc0);
      checks++;
      if (fwd_n[i] != exp_n) begin failures++;
        $display("FAIL %s dut%0d fwd_count: got %0d want %0d", name, i, fwd_n[i], exp_n); end
      mism = 0;
      for (int k = 0; k < fwd_n[i] && k < exp_n; k++) if (fwd_a[i][k] != exp_a[k]) mism++;
      checks++;
      if (mism != 0) begin failures++;
        $display("FAIL %s dut%0d fwd_bits: got %0d wrong bits want 0", name, i, mism); end
      checks++;
      if (start_cnt[i] != int'(e_start) || start_bad[i] != 0) begin failures++;
        $display("FAIL %s dut%0d start_rc_crc: got %0d pulses (%0d misplaced) want %0d", name, i,
                 start_cnt[i], start_bad[i], e_start); end
      checks++;
      if (end_cnt[i] != int'(e_end)) begin failures++;
        $display("FAIL %s dut%0d end_rc_crc: got %0d pulses want %0d", name, i, end_cnt[i], e_end); end
      checks++;
      if (ok_cnt[i] != int'(e_ok)) begin failures++;
        $display("FAIL %s dut%0d pkt_ok: got %0d pulses want %0d", name, i, ok_cnt[i], e_ok); end
      if (e_ok && e_end) begin
        checks++;
        if (ok_cyc[i] != end_cyc[i] + 1) begin failures++;
          $display("FAIL %s dut%0d pkt_ok_timing: got cycle %0d want %0d", name, i, ok_cyc[i], end_cyc[i] + 1); end
      end
      checks++;
      if (perr[i] !== e_perr || lerr[i] !== e_lerr) begin failures++;
        $display("FAIL %s dut%0d errors: got PID_error=%b len_error=%b want %b %b", name, i,
                 perr[i], lerr[i], e_perr, e_lerr); end
      checks++;
      if (pv[i] !== e_pv) begin failures++;
        $display("FAIL %s dut%0d pid_valid: got %b want %b", name, i, pv[i], e_pv); end
      if (e_pv) begin
        checks++;
        if (pidw[i] !== e_pid || ptw[i] !== e_pid[1:0]) begin failures++;
          $display("FAIL %s dut%0d pid: got %h/%b want %h/%b", name, i, pidw[i], ptw[i], e_pid, e_pid[1:0]); end
      end
      checks++;
      if (gbc != e_bc) begin failures++;
        $display("FAIL %s dut%0d bit_count: got %0d want %0d", name, i, gbc, e_bc); end
      checks++;
      if (wt[i] !== !e_err[i]) begin failures++;
        $display("FAIL %s dut%0d wait: got %b want %b", name, i, wt[i], !e_err[i]); end
    end

    if (abort_ack) begin
      abort = 1'b1; rc_PIDerror = 1'b1;
      step();
      abort = 1'b0; rc_PIDerror = 1'b0;
      for (int i = 0; i < 2; i++) begin
        gbc = (i == 1) ? int'(bc1) : int'(bc0);
        checks++;
        if (perr[i] !== 1'b0 || lerr[i] !== 1'b0 || wt[i] !== 1'b1 || pv[i] !== 1'b0 || gbc != 0) begin
          failures++;
          $display("FAIL %s dut%0d abort_ack: got perr=%b lerr=%b wait=%b pv=%b bc=%0d want 0 0 1 0 0",
                   name, i, perr[i], lerr[i], wt[i], pv[i], gbc); end
      end
    end else if (any_err) begin
      rc_PIDerror = 1'b1;
      for (int i = 0; i < 2; i++) if (e_err[i]) begin
        checks++;
        if ((perr[i] | lerr[i]) !== 1'b1) begin failures++;
          $display("FAIL %s dut%0d ack_hold: got %b want 1", name, i, perr[i] | lerr[i]); end
      end
      step();
      rc_PIDerror = 1'b0;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (perr[i] !== 1'b0 || lerr[i] !== 1'b0 || wt[i] !== 1'b1) begin failures++;
          $display("FAIL %s dut%0d ack_clear: got perr=%b lerr=%b wait=%b want 0 0 1",
                   name, i, perr[i], lerr[i], wt[i]); end
      end
    end
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({wt[i], sov[i], so[i], st[i], en[i], okw[i], pv[i], perr[i], lerr[i]} !== 9'b1_0000_0000
          || pidw[i] !== 4'h0 || ((i == 1) ? int'(bc1) : int'(bc0)) != 0) begin
        failures++;
        $display("FAIL reset dut%0d: got wait=%b sov=%b st=%b en=%b ok=%b pv=%b perr=%b lerr=%b pid=%h",
                 i, wt[i], sov[i], st[i], en[i], okw[i], pv[i], perr[i], lerr[i], pidw[i]);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_ack();           run_pkt(8'hD2, 0, -1, -1, 30, 0, "ack");           endtask
  task automatic test_data0_gaps();    run_pkt(8'hC3, 64, -1, -1, 40, 0, "data0");        endtask
  task automatic test_token_short();   run_pkt(8'h69, 15, -1, -1, 20, 0, "token15");      endtask
  task automatic test_bad_pid();       run_pkt(8'hD3, 20, -1, -1, 20, 0, "bad_pid");      endtask
  task automatic test_trunc_pid();     run_pkt(8'hD2, 0, 5, -1, 20, 1, "trunc_pid");      endtask

  task automatic test_abort_payload();
    run_pkt(8'h4B, 40, -1, 28, 20, 0, "abort_data1");
    run_pkt(8'hE1, 16, -1, -1, 20, 0, "after_abort");
  endtask

  task automatic test_boundaries();
    run_pkt(8'hC3, 1024, -1, -1, 5, 0, "data_1024");
    run_pkt(8'hC3, 1100, -1, -1, 5, 0, "data_sat");
    run_pkt(8'hC3, 16, -1, -1, 10, 0, "data_16");
    run_pkt(8'hC3, 8, -1, -1, 10, 0, "data_8");
    run_pkt(8'h3C, 5, -1, -1, 10, 0, "pre_none");
    run_pkt(8'h69, 17, -1, -1, 10, 0, "token17");
  endtask

  task automatic test_back_to_back();
    int lens [10] = '{0, 8, 15, 16, 17, 24, 32, 40, 64, 72};
    logic [3:0] lo;
    logic [7:0] pv8;
    for (int n = 0; n < 10; n++) begin
      lo  = 4'($urandom_range(0, 15));
      pv8 = {~lo, lo};
      if ($urandom_range(0, 4) == 0) pv8[$urandom_range(0, 7)] ^= 1'b1;
      run_pkt(pv8, lens[$urandom_range(0, 9)], -1, -1, $urandom_range(0, 50), 0, "random");
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; abort = 1'b0; start_decode = 1'b0; end_decode = 1'b0;
    s_in = 1'b0; bit_valid = 1'b0; rc_PIDerror = 1'b0;
    #1;
    test_reset();
    test_ack();
    test_data0_gaps();
    test_token_short();
    test_bad_pid();
    test_trunc_pid();
    test_abort_payload();
    test_boundaries();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
